vector_div_issue_ctrl: RTL

//  Issue/collect stage wrapped around signed_vector_division (57-bit {x,y,z}, 19-bit sign-magnitude
//  Q8.10 per component; divider has no handshake and a fixed 2-edge latency).

---
 rtl/vector_div_issue_ctrl_if.sv | 24 ++
 rtl/vector_div_issue_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/vector_div_issue_ctrl_if.sv
// Operand-in / result-out handshake bundle for the divider issue/collect stage.
interface vector_div_issue_ctrl_if #(
    parameter int VECTOR_WIDTH = 57,
    parameter int NUM_COMP     = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [VECTOR_WIDTH-1:0] in_vector_1;
    logic [VECTOR_WIDTH-1:0] in_vector_2;
    logic                    out_valid;
    logic                    out_ready;
    logic [VECTOR_WIDTH-1:0] out_vector;
    logic [NUM_COMP-1:0]     out_div0;

    modport master (
        output in_valid, in_vector_1, in_vector_2, out_ready,
        input  in_ready, out_valid, out_vector, out_div0
    );

    modport slave (
        input  in_valid, in_vector_1, in_vector_2, out_ready,
        output in_ready, out_valid, out_vector, out_div0
    );
endinterface

// File: rtl/vector_div_issue_ctrl.sv
// Issue/collect stage around a fixed-latency, handshake-free sign-magnitude vector divider:
// input FIFO, credit-gated issue, in-flight valid pipe, result FIFO with divide-by-zero flags.
module vector_div_comp #(
    parameter int COMP_WIDTH = 19
) (
    input  logic [COMP_WIDTH-1:0] divisor,
    input  logic [COMP_WIDTH-1:0] quotient,
    input  logic                  div0,
    output logic [COMP_WIDTH-1:0] divisor_safe,
    output logic [COMP_WIDTH-1:0] quotient_sat,
    output logic                  is_zero
);
    localparam int MW = COMP_WIDTH - 1;

    // Zero magnitude (either sign) is replaced by 1 ulp so the divider never divides by zero.
    assign is_zero      = (divisor[MW-1:0] == '0);
    assign divisor_safe = is_zero ? {divisor[MW], MW'(1)} : divisor;
    assign quotient_sat = div0 ? {quotient[MW], {MW{1'b1}}} : quotient;
endmodule

module vector_div_issue_ctrl #(
    parameter int VECTOR_WIDTH = 57,
    parameter int COMP_WIDTH   = 19,
    parameter int IN_DEPTH     = 4,
    parameter int RES_DEPTH    = 4,
    parameter int DIV_LATENCY  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    vector_div_issue_ctrl_if.slave        bus,
    output logic [VECTOR_WIDTH-1:0]       div_vector_1,
    output logic [VECTOR_WIDTH-1:0]       div_vector_2,
    input  logic [VECTOR_WIDTH-1:0]       div_out_vector
);
    localparam int NC  = VECTOR_WIDTH / COMP_WIDTH;
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int FW  = $clog2(DIV_LATENCY + 2);
    localparam int CW  = RAW + FW + 1;
    localparam logic [IAW:0]  IN_FULL  = (IAW+1)'(IN_DEPTH);
    localparam logic [RAW:0]  RES_FULL = (RAW+1)'(RES_DEPTH);
    localparam logic [CW-1:0] RES_CRED = CW'(RES_DEPTH);

    logic [VECTOR_WIDTH-1:0] in_mem1 [IN_DEPTH];
    logic [VECTOR_WIDTH-1:0] in_mem2 [IN_DEPTH];
    logic [IAW-1:0]          in_wr, in_rd;
    logic [IAW:0]            in_count;

    logic [VECTOR_WIDTH-1:0] res_mem  [RES_DEPTH];
    logic [NC-1:0]           res_div0 [RES_DEPTH];
    logic [RAW-1:0]          res_wr, res_rd;
    logic [RAW:0]            res_count;

    logic [DIV_LATENCY:0]           vld_pipe;
    logic [DIV_LATENCY:0][NC-1:0]   div0_pipe;
    logic [FW-1:0]                  inflight;

    logic [VECTOR_WIDTH-1:0] head_v1, head_v2, safe_v2, cap_vec;
    logic [NC-1:0]           zero_flags;
    logic                    push, pop, issue, cap;

    assign head_v1 = in_mem1[in_rd];
    assign head_v2 = in_mem2[in_rd];

    for (genvar g = 0; g < NC; g++) begin : g_comp
        vector_div_comp #(.COMP_WIDTH(COMP_WIDTH)) u_comp (
            .divisor      (head_v2[g*COMP_WIDTH +: COMP_WIDTH]),
            .quotient     (div_out_vector[g*COMP_WIDTH +: COMP_WIDTH]),
            .div0         (div0_pipe[DIV_LATENCY][g]),
            .divisor_safe (safe_v2[g*COMP_WIDTH +: COMP_WIDTH]),
            .quotient_sat (cap_vec[g*COMP_WIDTH +: COMP_WIDTH]),
            .is_zero      (zero_flags[g])
        );
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= DIV_LATENCY; i++) inflight = inflight + FW'(vld_pipe[i]);
    end

    assign bus.in_ready  = (in_count != IN_FULL);
    assign bus.out_valid = (res_count != '0);
    assign bus.out_vector = res_mem[res_rd];
    assign bus.out_div0   = res_div0[res_rd];

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;
    assign cap  = vld_pipe[DIV_LATENCY];
    // A same-cycle pop frees a slot, so it counts as a credit; keeps 1 result/cycle when streaming.
    assign issue = (in_count != '0) &&
                   ((CW'(inflight) + CW'(res_count)) < (RES_CRED + CW'(pop)));

    always_ff @(posedge clk) begin
        if (push) begin
            in_mem1[in_wr] <= bus.in_vector_1;
            in_mem2[in_wr] <= bus.in_vector_2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_wr        <= '0;
            in_rd        <= '0;
            in_count     <= '0;
            res_wr       <= '0;
            res_rd       <= '0;
            res_count    <= '0;
            vld_pipe     <= '0;
            div0_pipe    <= '0;
            div_vector_1 <= '0;
            div_vector_2 <= '0;
            for (int i = 0; i < RES_DEPTH; i++) begin
                res_mem[i]  <= '0;
                res_div0[i] <= '0;
            end
        end else begin
            if (push) in_wr <= in_wr + 1'b1;
            if (issue) begin
                in_rd        <= in_rd + 1'b1;
                div_vector_1 <= head_v1;
                div_vector_2 <= safe_v2;
            end
            case ({push, issue})
                2'b10:   in_count <= in_count + 1'b1;
                2'b01:   in_count <= in_count - 1'b1;
                default: ;
            endcase

            vld_pipe  <= {vld_pipe[DIV_LATENCY-1:0], issue};
            div0_pipe <= {div0_pipe[DIV_LATENCY-1:0], issue ? zero_flags : '0};

            if (cap) begin
                res_mem[res_wr]  <= cap_vec;
                res_div0[res_wr] <= div0_pipe[DIV_LATENCY];
                res_wr           <= res_wr + 1'b1;
            end
            if (pop) res_rd <= res_rd + 1'b1;
            case ({cap, pop})
                2'b10:   res_count <= res_count + 1'b1;
                2'b01:   res_count <= res_count - 1'b1;
                default: ;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(cap && !pop && res_count == RES_FULL));
endmodule
